// File: rtl/list_sum_ctrl.sv
// Controller for the linked-list summation datapath: sequences INIT/ADD/LINK per node,
// counts nodes, and traps into a sticky ERR state when a list runs past MAX_NODES.
module list_sum_ctrl #(
   parameter int N         = 8,
   parameter int MAX_NODES = 255,
   parameter int CW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          NEXT_ZERO,
   output logic          LD_SUM,
   output logic          LD_NEXT,
   output logic          SUM_SEL,
   output logic          NEXT_SEL,
   output logic          A_SEL,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [CW-1:0] node_count
);

   if ((N < 1) || (CW < 1) || (MAX_NODES < 1) || ((2 ** CW) <= MAX_NODES)) begin : g_param_check
      $error("list_sum_ctrl: need N>=1, MAX_NODES>=1 and 2**CW > MAX_NODES");
   end

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NODES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_ADD  = 3'd2,
      S_LINK = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] node_count_q, node_count_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         node_count_q <= '0;
      end else begin
         state_q      <= state_d;
         node_count_q <= node_count_d;
      end
   end

   // Outputs depend on state only; NEXT_ZERO steers the LINK exit and nothing else.
   always_comb begin
      state_d      = state_q;
      node_count_d = node_count_q;
      LD_SUM       = 1'b0;
      LD_NEXT      = 1'b0;
      SUM_SEL      = 1'b0;
      NEXT_SEL     = 1'b0;
      A_SEL        = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_INIT;
         end
         S_INIT: begin
            LD_SUM       = 1'b1;
            LD_NEXT      = 1'b1;
            busy         = 1'b1;
            node_count_d = '0;
            state_d      = S_ADD;
         end
         S_ADD: begin
            LD_SUM       = 1'b1;
            SUM_SEL      = 1'b1;
            busy         = 1'b1;
            node_count_d = node_count_q + CW'(1);
            state_d      = S_LINK;
         end
         S_LINK: begin
            A_SEL    = 1'b1;
            LD_NEXT  = 1'b1;
            NEXT_SEL = 1'b1;
            busy     = 1'b1;
            if (NEXT_ZERO)                    state_d = S_DONE;
            else if (node_count_q == MAX_CNT) state_d = S_ERR;
            else                              state_d = S_ADD;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = start ? S_INIT : S_IDLE;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) state_d = S_INIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign node_count = node_count_q;

endmodule

// File: tb/tb_list_sum_ctrl.sv
// Directed bench for list_sum_ctrl with a behavioural datapath (sum/next regs, 256-byte memory).
module tb_list_sum_ctrl;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          NEXT_ZERO;
   logic          LD_SUM, LD_NEXT, SUM_SEL, NEXT_SEL, A_SEL, busy, done, err;
   logic [CW-1:0] node_count;

   list_sum_ctrl #(.N(8), .MAX_NODES(4), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .NEXT_ZERO(NEXT_ZERO),
      .LD_SUM(LD_SUM), .LD_NEXT(LD_NEXT), .SUM_SEL(SUM_SEL), .NEXT_SEL(NEXT_SEL),
      .A_SEL(A_SEL), .busy(busy), .done(done), .err(err), .node_count(node_count)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   logic [7:0] sum_q, next_q, addr, rdata, next_in;

   assign addr      = A_SEL ? next_q + 8'd1 : next_q;
   assign rdata     = mem[addr];
   assign next_in   = NEXT_SEL ? rdata : 8'd0;
   assign NEXT_ZERO = (next_in == 8'd0);

   always_ff @(posedge clk) begin
      if (LD_SUM)  sum_q  <= SUM_SEL ? sum_q + rdata : 8'd0;
      if (LD_NEXT) next_q <= next_in;
   end

   // {LD_SUM, LD_NEXT, SUM_SEL, NEXT_SEL, A_SEL, busy, done, err}
   localparam logic [7:0] C_IDLE = 8'b0000_0000;
   localparam logic [7:0] C_INIT = 8'b1100_0100;
   localparam logic [7:0] C_ADD  = 8'b1010_0100;
   localparam logic [7:0] C_LINK = 8'b0101_1100;
   localparam logic [7:0] C_DONE = 8'b0000_0010;
   localparam logic [7:0] C_ERR  = 8'b0000_0001;

   typedef struct packed {
      logic [7:0][7:0] wa;
      logic [7:0][7:0] wd;
      logic [3:0]      nw;
      logic [7:0]      exp_sum;
      logic [7:0]      exp_cnt;
      logic [7:0]      exp_edges;
      logic            exp_err;
   } vec_t;

   vec_t vecs [6];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [7:0] ctrl_now();
      return {LD_SUM, LD_NEXT, SUM_SEL, NEXT_SEL, A_SEL, busy, done, err};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic add_w(input int i, input logic [7:0] a, input logic [7:0] d);
      vecs[i].wa[vecs[i].nw] = a;
      vecs[i].wd[vecs[i].nw] = d;
      vecs[i].nw             = vecs[i].nw + 4'd1;
   endtask

   task automatic set_exp(input int i, input logic [7:0] s, input logic [7:0] c,
                          input logic [7:0] e, input logic er);
      vecs[i].exp_sum   = s;
      vecs[i].exp_cnt   = c;
      vecs[i].exp_edges = e;
      vecs[i].exp_err   = er;
   endtask

   task automatic load_mem(input vec_t v);
      for (int i = 0; i < 256; i++) mem[i] = 8'd0;
      for (int i = 0; i < int'(v.nw); i++) mem[v.wa[i]] = v.wd[i];
   endtask

   // Pulses start for one sampling edge, then walks the run checking the control word each cycle.
   task automatic run_vec(input vec_t v, input bit pulse_mid);
      int m;
      load_mem(v);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      m = 0;
      while (!(done || err) && m < 40) begin
         if (m == 0)          chk("ctrl_init", int'(ctrl_now()), int'(C_INIT));
         else if (m % 2 == 1) chk("ctrl_add",  int'(ctrl_now()), int'(C_ADD));
         else                 chk("ctrl_link", int'(ctrl_now()), int'(C_LINK));
         start = (pulse_mid && m == 3);
         @(negedge clk);
         m++;
      end
      start = 1'b0;
      chk("edges_to_finish", m, int'(v.exp_edges));
      chk("ctrl_final", int'(ctrl_now()), v.exp_err ? int'(C_ERR) : int'(C_DONE));
      chk("node_count", int'(node_count), int'(v.exp_cnt));
      if (!v.exp_err) begin
         chk("sumout", int'(sum_q), int'(v.exp_sum));
         @(negedge clk);
         chk("ctrl_idle_after_done", int'(ctrl_now()), int'(C_IDLE));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int m;
      for (int i = 0; i < 6; i++) vecs[i] = '0;
      add_w(0, 8'd0, 8'd5);   add_w(0, 8'd1, 8'd0);
      set_exp(0, 8'd5, 8'd1, 8'd3, 1'b0);
      add_w(1, 8'd0, 8'd3);   add_w(1, 8'd1, 8'd4);   add_w(1, 8'd4, 8'd10);
      add_w(1, 8'd5, 8'd8);   add_w(1, 8'd8, 8'd7);   add_w(1, 8'd9, 8'd0);
      set_exp(1, 8'd20, 8'd3, 8'd7, 1'b0);
      add_w(2, 8'd0, 8'd200); add_w(2, 8'd1, 8'd2);   add_w(2, 8'd2, 8'd100); add_w(2, 8'd3, 8'd0);
      set_exp(2, 8'd44, 8'd2, 8'd5, 1'b0);
      add_w(3, 8'd0, 8'd1);   add_w(3, 8'd1, 8'd2);   add_w(3, 8'd2, 8'd2);   add_w(3, 8'd3, 8'd4);
      add_w(3, 8'd4, 8'd3);   add_w(3, 8'd5, 8'd6);   add_w(3, 8'd6, 8'd4);   add_w(3, 8'd7, 8'd0);
      set_exp(3, 8'd10, 8'd4, 8'd9, 1'b0);
      add_w(4, 8'd0, 8'd0);   add_w(4, 8'd1, 8'd255); add_w(4, 8'd255, 8'd7);
      set_exp(4, 8'd7, 8'd2, 8'd5, 1'b0);
      add_w(5, 8'd0, 8'd1);   add_w(5, 8'd1, 8'd2);   add_w(5, 8'd2, 8'd1);   add_w(5, 8'd3, 8'd2);
      set_exp(5, 8'd0, 8'd4, 8'd9, 1'b1);

      repeat (3) @(negedge clk);
      chk("reset_ctrl", int'(ctrl_now()), int'(C_IDLE));
      chk("reset_node_count", int'(node_count), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ctrl", int'(ctrl_now()), int'(C_IDLE));

      for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

      run_vec(vecs[5], 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("err_sticky_ctrl", int'(ctrl_now()), int'(C_ERR));
         chk("err_sticky_count", int'(node_count), 4);
      end
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("err_restart_init", int'(ctrl_now()), int'(C_INIT));
      repeat (3) @(negedge clk);
      chk("mid_add_ctrl", int'(ctrl_now()), int'(C_ADD));
      chk("mid_add_count", int'(node_count), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_ctrl", int'(ctrl_now()), int'(C_IDLE));
      chk("async_reset_count", int'(node_count), 0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      run_vec(vecs[1], 1'b0);

      run_vec(vecs[1], 1'b1);

      start = 1'b1;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         chk("held_start_init", int'(ctrl_now()), int'(C_INIT));
         m = 0;
         while (!done && m < 40) begin
            @(negedge clk);
            m++;
         end
         chk("held_start_edges", m, 7);
         chk("held_start_sum", int'(sum_q), 20);
         chk("held_start_count", int'(node_count), 3);
      end
      start = 1'b0;
      @(negedge clk);
      chk("held_release_idle", int'(ctrl_now()), int'(C_IDLE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
